// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared requester indices and helpers for the decoder memory arbiter
package decoder_pkg;

  localparam int NUM_REQ = 3;
  localparam int TAG_W   = 2;

  localparam logic [TAG_W-1:0] BUF  = 2'd0;
  localparam logic [TAG_W-1:0] RAM0 = 2'd1;
  localparam logic [TAG_W-1:0] RAM1 = 2'd2;

  // Successor in the round-robin ring BUF -> RAM0 -> RAM1 -> BUF.
  function automatic logic [TAG_W-1:0] next_req(input logic [TAG_W-1:0] idx);
    return (idx == RAM1) ? BUF : idx + 2'd1;
  endfunction

endpackage

// File: rtl/decoder_tag_fifo.sv
// rtl/decoder_tag_fifo.sv - in-order FIFO of requester tags for outstanding memory requests
module decoder_tag_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_tag_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign head_tag_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/decoder_mem_arb.sv
// rtl/decoder_mem_arb.sv - round-robin arbiter of three requesters onto one in-order memory port
module decoder_mem_arb
  import decoder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            up_req_valid_i,
  input  logic [3*ADDR_W-1:0]   up_req_addr_i,
  input  logic [3*8-1:0]        up_req_wmask_i,
  input  logic [3*64-1:0]       up_req_data_i,
  input  logic [2:0]            up_req_cmd_i,
  output logic [2:0]            up_req_ready_o,
  output logic [2:0]            up_rsp_valid_o,
  output logic [63:0]           up_rsp_data_o,
  output logic                  up_rsp_err_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic [7:0]            mem_req_wmask_o,
  output logic [63:0]           mem_req_data_o,
  output logic                  mem_req_cmd_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [63:0]           mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  output logic                  unexp_rsp_o
);

  logic [TAG_W-1:0]   rr_q;
  logic [TAG_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   scan;
  logic [TAG_W-1:0]   head_tag;
  logic [NUM_REQ-1:0] grant;
  logic               gnt_found;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               rsp_pop;

  always_comb begin
    grant     = '0;
    gnt_idx   = rr_q;
    gnt_found = 1'b0;
    scan      = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && up_req_valid_i[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
      scan = next_req(scan);
    end
    // A full tag FIFO blocks the grant outright, even when a response pops this cycle.
    if (gnt_found && !fifo_full && !rst_i) grant[gnt_idx] = 1'b1;
  end

  assign mem_req_valid_o = |grant;
  assign up_req_ready_o  = grant & {NUM_REQ{mem_req_ready_i}};
  assign accept          = mem_req_valid_o & mem_req_ready_i;

  always_comb begin
    mem_req_addr_o  = '0;
    mem_req_wmask_o = '0;
    mem_req_data_o  = '0;
    mem_req_cmd_o   = 1'b0;
    if (mem_req_valid_o) begin
      mem_req_addr_o  = up_req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_req_wmask_o = up_req_wmask_i[int'(gnt_idx)*8 +: 8];
      mem_req_data_o  = up_req_data_i[int'(gnt_idx)*64 +: 64];
      mem_req_cmd_o   = up_req_cmd_i[gnt_idx];
    end
  end

  assign rsp_pop       = mem_rsp_valid_i & ~fifo_empty & ~rst_i;
  assign up_rsp_data_o = mem_rsp_data_i;
  assign up_rsp_err_o  = mem_rsp_err_i;

  always_comb begin
    up_rsp_valid_o = '0;
    if (rsp_pop) up_rsp_valid_o[head_tag] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= BUF;
      unexp_rsp_o <= 1'b0;
    end else begin
      if (accept) rr_q <= next_req(gnt_idx);
      if (mem_rsp_valid_i && fifo_empty) unexp_rsp_o <= 1'b1;
    end
  end

  decoder_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_tag_i (gnt_idx),
    .pop_i      (rsp_pop),
    .head_tag_o (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_decoder_mem_arb.sv
// tb/tb_decoder_mem_arb.sv - scoreboard bench for the decoder memory arbiter
module tb_decoder_mem_arb;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [2:0]     up_req_valid_i;
  logic [3*AW-1:0] up_req_addr_i;
  logic [23:0]    up_req_wmask_i;
  logic [191:0]   up_req_data_i;
  logic [2:0]     up_req_cmd_i;
  logic [2:0]     up_req_ready_o;
  logic [2:0]     up_rsp_valid_o;
  logic [63:0]    up_rsp_data_o;
  logic           up_rsp_err_o;
  logic           mem_req_valid_o;
  logic [AW-1:0]  mem_req_addr_o;
  logic [7:0]     mem_req_wmask_o;
  logic [63:0]    mem_req_data_o;
  logic           mem_req_cmd_o;
  logic           mem_req_ready_i;
  logic           mem_rsp_valid_i;
  logic [63:0]    mem_rsp_data_i;
  logic           mem_rsp_err_i;
  logic           unexp_rsp_o;

  decoder_mem_arb #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .up_req_valid_i  (up_req_valid_i),
    .up_req_addr_i   (up_req_addr_i),
    .up_req_wmask_i  (up_req_wmask_i),
    .up_req_data_i   (up_req_data_i),
    .up_req_cmd_i    (up_req_cmd_i),
    .up_req_ready_o  (up_req_ready_o),
    .up_rsp_valid_o  (up_rsp_valid_o),
    .up_rsp_data_o   (up_rsp_data_o),
    .up_rsp_err_o    (up_rsp_err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_cmd_o   (mem_req_cmd_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .unexp_rsp_o     (unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  int         exp_tags[$];
  int         m_rr;
  logic       m_unexp;
  int         exp_gidx;
  logic       exp_mvalid;
  logic [2:0] exp_ready;
  logic [2:0] exp_rsp;

  task automatic model_eval();
    int idx;
    exp_gidx   = -1;
    exp_mvalid = 1'b0;
    exp_ready  = '0;
    exp_rsp    = '0;
    if (!rst_i) begin
      if (exp_tags.size() < DEPTH) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_rr + k) % 3;
          if (exp_gidx < 0 && up_req_valid_i[idx]) exp_gidx = idx;
        end
      end
      exp_mvalid = (exp_gidx >= 0);
      if (exp_mvalid && mem_req_ready_i) exp_ready[exp_gidx] = 1'b1;
      if (mem_rsp_valid_i && exp_tags.size() > 0) exp_rsp[exp_tags[0]] = 1'b1;
    end
  endtask

  task automatic model_clock();
    if (rst_i) begin
      exp_tags.delete();
      m_rr    = 0;
      m_unexp = 1'b0;
    end else begin
      if (mem_rsp_valid_i) begin
        if (exp_tags.size() > 0) void'(exp_tags.pop_front());
        else m_unexp = 1'b1;
      end
      if (exp_mvalid && mem_req_ready_i) begin
        exp_tags.push_back(exp_gidx);
        m_rr = (exp_gidx + 1) % 3;
      end
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic rdy, input logic rv,
                       input logic [63:0] rd, input logic re);
    @(negedge clk_i);
    up_req_valid_i  = v;
    mem_req_ready_i = rdy;
    mem_rsp_valid_i = rv;
    mem_rsp_data_i  = rd;
    mem_rsp_err_i   = re;
    for (int i = 0; i < 3; i++) begin
      up_req_addr_i[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100 + 32'($urandom_range(0, 255));
      up_req_wmask_i[i*8 +: 8]  = 8'($urandom);
      up_req_data_i[i*64 +: 64] = {$urandom, $urandom};
      up_req_cmd_i[i]           = 1'($urandom);
    end
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(3'b111, 1'b1, 1'b1, 64'h55, 1'b1);
    checks++; if (up_req_ready_o !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", up_req_ready_o); end
    checks++; if (mem_req_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", mem_req_valid_o); end
    checks++; if (up_rsp_valid_o !== 3'b000) begin failures++; $display("FAIL reset_rsp got=%b exp=000", up_rsp_valid_o); end
    checks++; if (unexp_rsp_o !== 1'b0) begin failures++; $display("FAIL reset_unexp got=%b exp=0", unexp_rsp_o); end
    checks++; if (up_rsp_data_o !== 64'h55 || up_rsp_err_o !== 1'b1) begin failures++; $display("FAIL reset_passthru got=%h/%b exp=55/1", up_rsp_data_o, up_rsp_err_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 3; k++) begin
      drive(3'b111, 1'b1, 1'b0, 64'h0, 1'b0);
      checks++; if (up_req_ready_o !== 3'(1 << k)) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, up_req_ready_o, 3'(1 << k)); end
      checks++; if (mem_req_addr_o !== up_req_addr_i[k*AW +: AW] || mem_req_data_o !== up_req_data_i[k*64 +: 64]) begin failures++; $display("FAIL rr_fields[%0d] got=%h exp=%h", k, mem_req_addr_o, up_req_addr_i[k*AW +: AW]); end
      tick();
    end
    drive(3'b111, 1'b0, 1'b0, 64'h0, 1'b0);
    checks++; if (mem_req_valid_o !== 1'b1 || up_req_ready_o !== 3'b000) begin failures++; $display("FAIL rr_hold got=%b/%b exp=1/000", mem_req_valid_o, up_req_ready_o); end
    checks++; if (mem_req_addr_o !== up_req_addr_i[0 +: AW]) begin failures++; $display("FAIL rr_wrap got=%h exp=%h", mem_req_addr_o, up_req_addr_i[0 +: AW]); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b0, 1'b1, 64'hD0 + 64'(k), 1'b0);
      checks++; if (up_rsp_valid_o !== 3'(1 << k) || up_rsp_data_o !== 64'hD0 + 64'(k)) begin failures++; $display("FAIL rr_rsp[%0d] got=%b/%h exp=%b/%h", k, up_rsp_valid_o, up_rsp_data_o, 3'(1 << k), 64'hD0 + 64'(k)); end
      tick();
    end
  endtask

  task automatic test_full();
    int n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(3'b010, 1'b1, 1'b0, 64'h0, 1'b0);
      if (up_req_ready_o[1]) n_acc++;
      tick();
    end
    checks++; if (n_acc !== 4) begin failures++; $display("FAIL full_accepts got=%0d exp=4", n_acc); end
    drive(3'b010, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (mem_req_valid_o !== 1'b0 || up_req_ready_o !== 3'b000) begin failures++; $display("FAIL full_block got=%b/%b exp=0/000", mem_req_valid_o, up_req_ready_o); end
    checks++; if (mem_req_addr_o !== '0 || mem_req_data_o !== '0 || mem_req_wmask_o !== '0) begin failures++; $display("FAIL full_fields_zero got=%h exp=0", mem_req_addr_o); end
    tick();
    drive(3'b010, 1'b1, 1'b1, 64'hF, 1'b0);
    checks++; if (up_req_ready_o !== 3'b000 || up_rsp_valid_o !== 3'b010) begin failures++; $display("FAIL full_pop_nogrant got=%b/%b exp=000/010", up_req_ready_o, up_rsp_valid_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b0, 1'b1, 64'h0, 1'b0);
      checks++; if (up_rsp_valid_o !== 3'b010) begin failures++; $display("FAIL full_drain[%0d] got=%b exp=010", k, up_rsp_valid_o); end
      tick();
    end
  endtask

  task automatic test_tag_order();
    logic [2:0] vseq [3] = '{3'b100, 3'b001, 3'b010};
    logic [63:0] dseq [3] = '{64'hA, 64'hB, 64'hC};
    for (int k = 0; k < 3; k++) begin
      drive(vseq[k], 1'b1, 1'b0, 64'h0, 1'b0);
      checks++; if (up_req_ready_o !== vseq[k]) begin failures++; $display("FAIL tag_accept[%0d] got=%b exp=%b", k, up_req_ready_o, vseq[k]); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b0, 1'b1, dseq[k], 1'b0);
      checks++; if (up_rsp_valid_o !== vseq[k] || up_rsp_data_o !== dseq[k]) begin failures++; $display("FAIL tag_rsp[%0d] got=%b/%h exp=%b/%h", k, up_rsp_valid_o, up_rsp_data_o, vseq[k], dseq[k]); end
      tick();
    end
  endtask

  task automatic test_simul_push_pop();
    int n_acc = 0;
    drive(3'b001, 1'b1, 1'b0, 64'h0, 1'b0); tick();
    drive(3'b010, 1'b1, 1'b0, 64'h0, 1'b0); tick();
    drive(3'b100, 1'b1, 1'b1, 64'h77, 1'b0);
    checks++; if (up_req_ready_o !== 3'b100 || up_rsp_valid_o !== 3'b001) begin failures++; $display("FAIL simul_push_pop got=%b/%b exp=100/001", up_req_ready_o, up_rsp_valid_o); end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(3'b001, 1'b1, 1'b0, 64'h0, 1'b0);
      if (up_req_ready_o[0]) n_acc++;
      tick();
    end
    checks++; if (n_acc !== 2) begin failures++; $display("FAIL simul_count got=%0d exp=2", n_acc); end
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 1'b0, 1'b1, 64'h0, 1'b0);
      checks++; if (up_rsp_valid_o !== exp_rsp) begin failures++; $display("FAIL simul_drain[%0d] got=%b exp=%b", k, up_rsp_valid_o, exp_rsp); end
      tick();
    end
  endtask

  task automatic test_unexpected();
    drive(3'b000, 1'b0, 1'b1, 64'h99, 1'b1);
    checks++; if (up_rsp_valid_o !== 3'b000 || up_rsp_data_o !== 64'h99 || up_rsp_err_o !== 1'b1) begin failures++; $display("FAIL unexp_drop got=%b/%h/%b exp=000/99/1", up_rsp_valid_o, up_rsp_data_o, up_rsp_err_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (unexp_rsp_o !== 1'b1) begin failures++; $display("FAIL unexp_sticky[%0d] got=%b exp=1", k, unexp_rsp_o); end
      drive(3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
      tick();
    end
    drive(3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    rst_i = 1'b1;
    #1;
    checks++; if (unexp_rsp_o !== 1'b0) begin failures++; $display("FAIL unexp_clear got=%b exp=0", unexp_rsp_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin drive(3'b111, 1'b1, 1'b0, 64'h0, 1'b0); tick(); end
    drive(3'b111, 1'b1, 1'b0, 64'h0, 1'b0);
    rst_i = 1'b1;
    #1;
    checks++; if (up_req_ready_o !== 3'b000 || mem_req_valid_o !== 1'b0) begin failures++; $display("FAIL mid_reset_gate got=%b/%b exp=000/0", up_req_ready_o, mem_req_valid_o); end
    tick();
    rst_i = 1'b0;
    drive(3'b000, 1'b0, 1'b1, 64'h5, 1'b0);
    checks++; if (up_rsp_valid_o !== 3'b000) begin failures++; $display("FAIL mid_reset_drop got=%b exp=000", up_rsp_valid_o); end
    tick();
    checks++; if (unexp_rsp_o !== 1'b1) begin failures++; $display("FAIL mid_reset_unexp got=%b exp=1", unexp_rsp_o); end
    drive(3'b111, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (up_req_ready_o !== 3'b001) begin failures++; $display("FAIL mid_reset_rr got=%b exp=001", up_req_ready_o); end
    tick();
    drive(3'b000, 1'b0, 1'b0, 64'h0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  v;
    logic        rdy;
    logic        rv;
    logic [AW-1:0] ea;
    logic [63:0] ed;
    logic [7:0]  em;
    logic        ec;
    for (int c = 0; c < 300; c++) begin
      v   = 3'($urandom_range(0, 7));
      rdy = 1'($urandom_range(0, 1));
      rv  = (exp_tags.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      drive(v, rdy, rv, {$urandom, $urandom}, 1'($urandom));
      ea = '0; ed = '0; em = '0; ec = 1'b0;
      if (exp_gidx >= 0) begin
        ea = up_req_addr_i[exp_gidx*AW +: AW];
        ed = up_req_data_i[exp_gidx*64 +: 64];
        em = up_req_wmask_i[exp_gidx*8 +: 8];
        ec = up_req_cmd_i[exp_gidx];
      end
      checks++; if (up_req_ready_o !== exp_ready || mem_req_valid_o !== exp_mvalid) begin failures++; $display("FAIL rand_grant[%0d] got=%b/%b exp=%b/%b", c, up_req_ready_o, mem_req_valid_o, exp_ready, exp_mvalid); end
      checks++; if (mem_req_addr_o !== ea || mem_req_data_o !== ed || mem_req_wmask_o !== em || mem_req_cmd_o !== ec) begin failures++; $display("FAIL rand_fields[%0d] got=%h/%h/%h/%b exp=%h/%h/%h/%b", c, mem_req_addr_o, mem_req_data_o, mem_req_wmask_o, mem_req_cmd_o, ea, ed, em, ec); end
      checks++; if (up_rsp_valid_o !== exp_rsp || up_rsp_data_o !== mem_rsp_data_i) begin failures++; $display("FAIL rand_rsp[%0d] got=%b exp=%b", c, up_rsp_valid_o, exp_rsp); end
      tick();
      checks++; if (unexp_rsp_o !== m_unexp) begin failures++; $display("FAIL rand_unexp[%0d] got=%b exp=%b", c, unexp_rsp_o, m_unexp); end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    up_req_valid_i  = '0;
    up_req_addr_i   = '0;
    up_req_wmask_i  = '0;
    up_req_data_i   = '0;
    up_req_cmd_i    = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
    m_rr            = 0;
    m_unexp         = 1'b0;
    test_reset();
    test_round_robin();
    test_full();
    test_tag_order();
    test_simul_push_pop();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_mem_arb.md
DECODER_MEM_ARB -- requirements
Module: decoder_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width (equal to acc_addr_width).
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding requests; power of two, at least 2.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port up_req_valid_i  in  3  per-requester request valid; index 0 = bitstream buffer, 1 = RAM0, 2 = RAM1.
REQ-006 SHALL have port up_req_addr_i  in  3*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port up_req_wmask_i  in  3*8  per-requester byte write mask.
REQ-008 SHALL have port up_req_data_i  in  3*64  per-requester write data.
REQ-009 SHALL have port up_req_cmd_i  in  3  per-requester command; 1 = read, 0 = write.
REQ-010 SHALL have port up_req_ready_o  out  3  per-requester accept.
REQ-011 SHALL have port up_rsp_valid_o  out  3  per-requester response valid.
REQ-012 SHALL have port up_rsp_data_o  out  64  response data, broadcast to all requesters.
REQ-013 SHALL have port up_rsp_err_o  out  1  response error, broadcast to all requesters.
REQ-014 SHALL have port mem_req_valid_o  out  1  downstream request valid.
REQ-015 SHALL have port mem_req_addr_o  out  ADDR_W  downstream address.
REQ-016 SHALL have port mem_req_wmask_o  out  8  downstream write mask.
REQ-017 SHALL have port mem_req_data_o  out  64  downstream write data.
REQ-018 SHALL have port mem_req_cmd_o  out  1  downstream command.
REQ-019 SHALL have port mem_req_ready_i  in  1  downstream accept.
REQ-020 SHALL have port mem_rsp_valid_i  in  1  downstream response valid; exactly one response per accepted request, returned in order, reads and writes alike.
REQ-021 SHALL have port mem_rsp_data_i  in  64  downstream response data.
REQ-022 SHALL have port mem_rsp_err_i  in  1  downstream response error.
REQ-023 SHALL have port unexp_rsp_o  out  1  sticky flag for a response received while nothing is outstanding.

Function
REQ-024 Grant SHALL be round-robin: starting from pointer rr, pick the first requester (rr, rr+1, rr+2 mod 3) with valid = 1; grant is combinational.
REQ-025 mem_req_valid_o SHALL be 1 only when some requester is valid and the tag FIFO is not full; the mem_req_* fields come from the granted requester, and fields SHALL be 0 when no requester is granted.
REQ-026 up_req_ready_o[i] SHALL equal grant[i] & mem_req_ready_i & ~full; the request path adds zero cycles of latency.
REQ-027 On accept (mem_req_valid_o & mem_req_ready_i), the granted index SHALL be pushed into the tag FIFO, and rr SHALL become (granted index + 1) mod 3 at the next edge; otherwise rr is held.
REQ-028 A requester holding valid SHALL be granted within 3 accepts; no requester is ever starved.
REQ-029 On mem_rsp_valid_i with the FIFO not empty: up_rsp_valid_o[head] = 1 in the same cycle, other bits 0, and the FIFO pops.
REQ-030 up_rsp_data_o and up_rsp_err_o SHALL pass mem_rsp_data_i and mem_rsp_err_i through combinationally.
REQ-031 On mem_rsp_valid_i with the FIFO empty, the response SHALL be dropped (all up_rsp_valid_o = 0) and unexp_rsp_o set to 1 until reset.
REQ-032 Push and pop in the same cycle SHALL leave the count unchanged. When the FIFO is full, no grant is made, even if a response pops that cycle.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH. The count has width $clog2(DEPTH)+1 and ranges 0..DEPTH.

Reset
REQ-034 While rst_i = 1: rr = 0, FIFO empty (count = 0, pointers = 0), unexp_rsp_o = 0, all up_req_ready_o / up_rsp_valid_o = 0, mem_req_valid_o = 0.
REQ-035 Reset mid-operation SHALL discard all outstanding tags; any response that arrives later SHALL be treated per REQ-031.

Structure
REQ-036 The requester index constants (BUF = 0, RAM0 = 1, RAM1 = 2) and NUM_REQ = 3 SHALL live in the shared decoder package.
REQ-037 The tag FIFO SHALL be a sub-module, decoder_tag_fifo (2-bit entries, DEPTH parameter, full/empty outputs).

Verification
REQ-038 Requesters 0, 1, 2 all valid, ready = 1 for 3 cycles -> accepts in order 0, 1, 2; rr returns to 0.
REQ-039 DEPTH = 4, ready = 1, no responses, requester 1 held valid -> exactly 4 accepts, then ready_o[1] = 0 and mem_req_valid_o = 0.
REQ-040 Tags {2, 0, 1} outstanding, 3 responses with data 0xA, 0xB, 0xC -> up_rsp_valid_o = 100b, 001b, 010b with matching data.
REQ-041 FIFO count = 2, accept and response in the same cycle -> count stays 2, response goes to the head tag.
REQ-042 Response with FIFO empty -> no up_rsp_valid_o bit set, unexp_rsp_o = 1 until rst_i is pulsed.
REQ-043 rst_i asserted with 3 tags outstanding -> count = 0 immediately; the next response sets unexp_rsp_o.
